// File: rtl/nbcac_decode_arbiter.sv
// rtl/nbcac_decode_arbiter.sv - round-robin arbiter sharing one NBCAC 23->16 decoder core
// Two-stage pipeline (capture, output) sustaining one decode per clock, results tagged by channel.

module nbcac_16di_decoder_core (
  input  logic [23:1] d,
  output logic [15:0] v
);
  // Fibonacci numeral-system weights: bit k carries F(k), F(1)=F(2)=1
  localparam logic [15:0] W [1:23] = '{
    16'd1,    16'd1,    16'd2,    16'd3,    16'd5,    16'd8,    16'd13,   16'd21,
    16'd34,   16'd55,   16'd89,   16'd144,  16'd233,  16'd377,  16'd610,  16'd987,
    16'd1597, 16'd2584, 16'd4181, 16'd6765, 16'd10946, 16'd17711, 16'd28657
  };

  always_comb begin
    v = '0;
    for (int k = 1; k <= 23; k++) begin
      if (d[k]) v = v + W[k];
    end
  end
endmodule

module nbcac_decode_arbiter #(
  parameter int NCH = 4,
  parameter int CHW = 2
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic [NCH-1:0]    req_valid,
  input  logic [NCH*23-1:0] req_code,
  output logic [NCH-1:0]    req_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_data,
  output logic [CHW-1:0]    out_chan,
  output logic [15:0]       dec_count,
  output logic              busy
);
  logic           cap_valid;
  logic [23:1]    cap_code;
  logic [CHW-1:0] cap_chan;
  logic [CHW-1:0] rr_ptr;
  logic [15:0]    core_v;
  logic           out_load;
  logic           cap_free;
  logic           grant_found;
  logic [CHW-1:0] grant_idx;
  logic [CHW:0]   scan;
  logic           accept;

  nbcac_16di_decoder_core u_core (
    .d (cap_code),
    .v (core_v)
  );

  assign out_load = cap_valid && (!out_valid || out_ready);
  assign cap_free = !cap_valid || out_load;
  assign busy     = cap_valid || out_valid;

  // Scan from rr_ptr with an explicit wrap so non-power-of-two NCH never grants an index >= NCH
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan        = '0;
    for (int k = 0; k < NCH; k++) begin
      scan = {1'b0, rr_ptr} + (CHW+1)'(k);
      if (scan >= (CHW+1)'(NCH)) scan = scan - (CHW+1)'(NCH);
      if (!grant_found && req_valid[scan[CHW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan[CHW-1:0];
      end
    end
  end

  assign accept = grant_found && cap_free;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cap_valid <= 1'b0;
      cap_code  <= '0;
      cap_chan  <= '0;
      rr_ptr    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      dec_count <= '0;
    end else begin
      if (accept) begin
        cap_valid <= 1'b1;
        cap_code  <= req_code[23*grant_idx +: 23];
        cap_chan  <= grant_idx;
        rr_ptr    <= (grant_idx == CHW'(NCH-1)) ? '0 : grant_idx + CHW'(1);
      end else if (out_load) begin
        cap_valid <= 1'b0;
      end

      if (out_load) begin
        out_valid <= 1'b1;
        out_data  <= core_v;
        out_chan  <= cap_chan;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (out_valid && out_ready) dec_count <= dec_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_nbcac_decode_arbiter.sv
// tb/tb_nbcac_decode_arbiter.sv - directed table-driven bench for nbcac_decode_arbiter
module tb_nbcac_decode_arbiter;
  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [91:0] req_code = '0;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [1:0]  out_chan;
  logic [15:0] dec_count;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int accepts = 0;

  nbcac_decode_arbiter #(.NCH(4), .CHW(2)) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_code  (req_code),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .dec_count (dec_count),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [3:0] valid;
    logic       ordy;
    logic [3:0] exp_rdy;
    logic       exp_ov;
    logic [1:0] exp_chan;
  } vec_t;

  vec_t tbl [7];

  function automatic logic [15:0] golden(input logic [22:0] c);
    int a, b, t, sum;
    a = 1; b = 1; sum = 0;
    for (int k = 0; k < 23; k++) begin
      if (c[k]) sum = sum + a;
      t = a + b; a = b; b = t;
    end
    return 16'(sum);
  endfunction

  function automatic logic [22:0] code_of(input logic [91:0] codes, input logic [1:0] ch);
    return codes[23*ch +: 23];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic samp();
    #2;
    accepts += $countones(req_valid & req_ready);
  endtask

  task automatic do_reset();
    req_valid = '0;
    out_ready = 1'b0;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0] = '{4'hF, 1'b1, 4'b0001, 1'b0, 2'd0};
    tbl[1] = '{4'hF, 1'b1, 4'b0010, 1'b0, 2'd0};
    tbl[2] = '{4'hF, 1'b1, 4'b0100, 1'b1, 2'd0};
    tbl[3] = '{4'hF, 1'b1, 4'b1000, 1'b1, 2'd1};
    tbl[4] = '{4'hF, 1'b1, 4'b0001, 1'b1, 2'd2};
    tbl[5] = '{4'hF, 1'b1, 4'b0010, 1'b1, 2'd3};
    tbl[6] = '{4'hF, 1'b1, 4'b0100, 1'b1, 2'd0};

    // Reset state
    cyc();
    #2;
    check("reset out_valid", 32'(out_valid), 0);
    check("reset out_data", 32'(out_data), 0);
    check("reset out_chan", 32'(out_chan), 0);
    check("reset dec_count", 32'(dec_count), 0);
    check("reset busy", 32'(busy), 0);
    check("reset req_ready", 32'(req_ready), 0);
    cyc();
    rst_n = 1'b1;

    // Single codeword on channel 0
    req_code = '0;
    req_valid = 4'b0001;
    out_ready = 1'b1;
    samp();
    check("t1 req_ready", 32'(req_ready), 32'h1);
    cyc();
    req_valid = '0;
    samp();
    check("t1 busy capture", 32'(busy), 1);
    check("t1 ov before", 32'(out_valid), 0);
    cyc();
    samp();
    check("t1 out_valid", 32'(out_valid), 1);
    check("t1 out_data", 32'(out_data), 0);
    check("t1 out_chan", 32'(out_chan), 0);
    cyc();
    samp();
    check("t1 dec_count", 32'(dec_count), 1);
    check("t1 idle", 32'(busy), 0);

    // Round robin at full throughput
    do_reset();
    req_code = {23'h155555, 23'h7FFFFF, 23'h400000, 23'h000001};
    for (int i = 0; i < 7; i++) begin
      req_valid = tbl[i].valid;
      out_ready = tbl[i].ordy;
      samp();
      check($sformatf("rr%0d req_ready", i), 32'(req_ready), 32'(tbl[i].exp_rdy));
      check($sformatf("rr%0d out_valid", i), 32'(out_valid), 32'(tbl[i].exp_ov));
      if (tbl[i].exp_ov) begin
        check($sformatf("rr%0d out_chan", i), 32'(out_chan), 32'(tbl[i].exp_chan));
        check($sformatf("rr%0d out_data", i), 32'(out_data),
              32'(golden(code_of(req_code, tbl[i].exp_chan))));
      end
      cyc();
    end

    // Backpressure: channels 1 and 2, consumer stalled
    do_reset();
    req_code = {23'h0, 23'h2AAAAA, 23'h7FFFFF, 23'h0};
    req_valid = 4'b0110;
    accepts = 0;
    samp();
    check("bp first grant", 32'(req_ready), 32'b0010);
    cyc();
    samp();
    check("bp second grant", 32'(req_ready), 32'b0100);
    cyc();
    for (int i = 0; i < 10; i++) begin
      samp();
      check($sformatf("bp hold%0d ready", i), 32'(req_ready), 0);
      check($sformatf("bp hold%0d chan", i), 32'(out_chan), 1);
      check($sformatf("bp hold%0d data", i), 32'(out_data), 32'(golden(23'h7FFFFF)));
      check($sformatf("bp hold%0d ov", i), 32'(out_valid), 1);
      cyc();
    end
    check("bp accepts", accepts, 2);
    req_valid = '0;
    out_ready = 1'b1;
    samp();
    check("bp drain1 chan", 32'(out_chan), 1);
    cyc();
    samp();
    check("bp drain2 ov", 32'(out_valid), 1);
    check("bp drain2 chan", 32'(out_chan), 2);
    check("bp drain2 data", 32'(out_data), 32'(golden(23'h2AAAAA)));
    cyc();
    samp();
    check("bp drained", 32'(out_valid), 0);
    check("bp dec_count", 32'(dec_count), 2);

    // Pointer hold while stalled with rr_ptr at 2
    do_reset();
    req_code = {23'h000003, 23'h000007, 23'h00000F, 23'h00001F};
    req_valid = 4'b0011;
    samp();
    cyc();
    samp();
    cyc();
    req_valid = 4'b1100;
    for (int i = 0; i < 3; i++) begin
      samp();
      check($sformatf("ph stall%0d ready", i), 32'(req_ready), 0);
      cyc();
    end
    out_ready = 1'b1;
    samp();
    check("ph release grant", 32'(req_ready), 32'b0100);
    check("ph release chan", 32'(out_chan), 0);
    cyc();
    samp();
    check("ph next grant", 32'(req_ready), 32'b1000);
    check("ph out chan1", 32'(out_chan), 1);
    cyc();
    samp();
    check("ph out chan2", 32'(out_chan), 2);
    check("ph out data2", 32'(out_data), 32'(golden(23'h000007)));
    cyc();

    // Asynchronous reset with both stages full
    out_ready = 1'b0;
    req_valid = 4'b0011;
    cyc();
    cyc();
    cyc();
    samp();
    check("ar full ov", 32'(out_valid), 1);
    check("ar full busy", 32'(busy), 1);
    check("ar full ready", 32'(req_ready), 0);
    rst_n = 1'b0;
    #1;
    check("ar out_valid", 32'(out_valid), 0);
    check("ar busy", 32'(busy), 0);
    check("ar dec_count", 32'(dec_count), 0);
    #1;
    rst_n = 1'b1;
    req_valid = 4'b1111;
    out_ready = 1'b1;
    #1;
    check("ar first grant", 32'(req_ready), 32'b0001);
    cyc();

    // dec_count wrap
    do_reset();
    req_code = '0;
    req_valid = 4'b0001;
    out_ready = 1'b1;
    begin
      int n;
      n = 0;
      while (dec_count != 16'hFFFF && n < 70000) begin
        cyc();
        n++;
      end
      check("wrap reached 65535", 32'(dec_count), 32'hFFFF);
    end
    samp();
    check("wrap ov", 32'(out_valid), 1);
    cyc();
    samp();
    check("wrap to zero", 32'(dec_count), 0);
    req_valid = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/nbcac_decode_arbiter.md
# nbcac_decode_arbiter

Round-robin scheduler that shares a single `nbcac_16di_decoder_core` (23-bit NBCAC codeword in, 16-bit data out) among `NCH` requesting channels. It sits between per-link codeword receivers and the downstream data consumer. Each request uses a valid/ready handshake. The block keeps a two-stage pipeline (capture register, then output register) and sustains one decode per clock. Every result is tagged with the channel it came from.

## Interface
- `NCH`, 4, number of requesting channels (2..8)
- `CHW`, 2, channel-index width, equal to clog2(`NCH`)
- `clock`  in  1  the single clock; all registers update on its rising edge
- `rst_n`  in  1  reset, asynchronous assert and active-low
- `req_valid`  in  `NCH`  channel i is presenting a codeword
- `req_code`  in  `NCH`*23  packed codewords; channel i occupies bits [23*i+22 : 23*i], mapped to core `d[23:1]`
- `req_ready`  out  `NCH`  channel i's codeword is accepted on this edge (one-hot or zero)
- `out_valid`  out  1  `out_data`/`out_chan` hold a decoded result
- `out_ready`  in  1  the consumer takes the result on this edge
- `out_data`  out  16  decoded data word
- `out_chan`  out  `CHW`  source channel of `out_data`
- `dec_count`  out  16  number of results delivered; wraps modulo 2^16
- `busy`  out  1  set when `cap_valid` or `out_valid` is set

## Operation
- Capture stage registers:
  - `cap_valid`, `cap_code[23:1]`, `cap_chan`
  - `cap_code` drives the core `d` input; the core output `v` feeds the output stage.
- Output stage registers: `out_valid`, `out_data`, `out_chan`.
- Pointer: `rr_ptr` (`CHW` bits) marks the highest-priority channel.
- Move conditions:
  - `out_load` = `cap_valid` and (not `out_valid` or `out_ready`)
  - `cap_free` = not `cap_valid` or `out_load`
- Grant selection:
  - The grant goes to the first i with `req_valid[i]=1`, scanning `rr_ptr`, `rr_ptr`+1, … modulo `NCH`.
  - `req_ready[g]` = `cap_free` for the granted index g; all other ready bits are 0.
  - `req_ready` is combinational from `req_valid`, `out_ready` and state.
- On an accepted request (`req_valid[g]` and `req_ready[g]`):
  - Capture stage loads `req_code[g]` and g, and sets `cap_valid`.
  - `rr_ptr` becomes (g+1) mod `NCH`.
- With no accept: `rr_ptr` holds, and `cap_valid` clears if `out_load` is set.
- On `out_load`:
  - `out_data` and `out_chan` load from the core output and `cap_chan`.
  - `out_valid` is set.
- Otherwise, `out_valid` clears when `out_ready` is seen.
- `dec_count` increments on each `out_valid` and `out_ready` edge and wraps 16'hFFFF to 0.
- Data integrity:
  - `out_data` and `out_chan` are stable while `out_valid` is set and `out_ready` is low.
  - A granted channel that does not see `req_ready` keeps priority: the pointer does not move without an accept.
- Reset asserted (asynchronous, mid-operation included):
  - Both stages are flushed.
  - In-flight codewords are discarded and not re-requested.
  - `rr_ptr` returns to 0.
- `NCH` not a power of two: pointer wrap is explicit (`NCH`-1 goes to 0), and indices ≥ `NCH` are never granted.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_chan`=0, `dec_count`=0
  - `cap_valid`=0, `rr_ptr`=0, `busy`=0
  - `req_ready` falls to 0 once `req_valid` is 0.
- Latency: a codeword accepted at edge k shows `out_valid`=1 after edge k+1, provided the output stage was free or drained at edge k+1.
- Throughput: one accept and one delivery per cycle while `out_ready`=1.
- Backpressure:
  - With `out_ready`=0 the pipeline fills within 2 accepts.
  - `req_ready` is then 0 until `out_ready` rises.
  - On the edge where `out_ready` rises with both stages full, capture moves to output and a new request is accepted in the same edge.
- The core is purely combinational between the capture and output registers. It adds no cycle, and it is the critical path.

## Test plan
- Reset, then `req_valid[0]`=1 with `req_code[0]`=0 and `out_ready`=1:
  - `req_ready`=4'b0001 at the first edge.
  - `out_valid`=1, `out_data`=16'h0000, `out_chan`=0 one cycle later.
  - `dec_count`=1 after delivery.
- All 4 channels valid continuously, `out_ready`=1:
  - Grants run 0,1,2,3,0,… on consecutive cycles.
  - `out_chan` follows the same order one cycle later.
  - Every `out_data` matches the core golden model for its channel's codeword.
- `out_ready`=0 with channels 1 and 2 requesting:
  - Exactly 2 accepts (channel 1, then channel 2), after which `req_ready`=0.
  - `out_data` and `out_chan`=1 hold unchanged for 10 cycles.
  - Raise `out_ready`: results arrive for channel 1, then channel 2, with no loss or duplication.
- Pointer hold: with `rr_ptr`=2 and the pipeline full, channels 2 and 3 request.
  - No grant and no pointer move while stalled.
  - On release, channel 2 is accepted first.
- Asynchronous reset pulse mid-stream with both stages full:
  - `out_valid`, `cap_valid`, `busy` and `dec_count` go to 0 immediately, without waiting for a clock edge.
  - After release, the first grant goes to channel 0.
- `dec_count` preloaded via 65535 deliveries: the next delivery wraps it to 0.
